// File: rtl/drive_pkg.sv
// Shared types and constants for the drivetrain arbiter slice.
// Holds the FSM state encoding, the default duty width and requester indices.
package drive_pkg;

    localparam int DUTY_W_DEF = 8;

    localparam int REQ_AVOID  = 0;
    localparam int REQ_LINE   = 1;
    localparam int REQ_REMOTE = 2;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RUN      = 3'd1,
        ST_DEADTIME = 3'd2,
        ST_FAULT    = 3'd3,
        ST_PAUSE    = 3'd4
    } state_e;

endpackage

// File: rtl/drive_timer.sv
// Loadable down-counter shared by the dead-time and pause intervals.
// Counts down to zero and rests there until the next load.
module drive_timer #(
    parameter int CNT_W = 17
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             zero
);

    logic [CNT_W-1:0] cnt_r;

    // Count register: load wins over decrement, saturates at zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_r <= '0;
        end else if (load) begin
            cnt_r <= load_val;
        end else if (cnt_r != '0) begin
            cnt_r <= cnt_r - CNT_W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign zero = (cnt_r == '0);

endmodule

// File: rtl/drive_arbiter.sv
// Drivetrain arbiter: fixed-priority grant of three requesters, dead time on
// direction reversal, and fault/pause sequencing of the motor enable.
module drive_arbiter
    import drive_pkg::*;
#(
    parameter int PAUSE_CYCLES    = 80000,
    parameter int DEADTIME_CYCLES = 1000,
    parameter int DUTY_W          = DUTY_W_DEF
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [1:0]                   Disable,
    input  logic [2:0]                   req,
    input  logic [2:0][1:0]              cmd_dir,
    input  logic [2:0][1:0][DUTY_W-1:0]  cmd_duty,
    output logic [2:0]                   grant,
    output logic                         dir_l,
    output logic                         dir_r,
    output logic [DUTY_W-1:0]            duty_l,
    output logic [DUTY_W-1:0]            duty_r,
    output logic                         Enable,
    output logic                         Pause,
    output logic [2:0]                   state
);

    localparam int MAX_CYCLES = (PAUSE_CYCLES > DEADTIME_CYCLES) ? PAUSE_CYCLES : DEADTIME_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);
    localparam logic [CNT_W-1:0] PAUSE_LOAD = CNT_W'(PAUSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] DEAD_LOAD  = CNT_W'(DEADTIME_CYCLES - 1);

    function automatic logic [2:0] prio_pick(input logic [2:0] r);
        logic [2:0] w;
        if (r[REQ_AVOID]) begin
            w = 3'b001;
        end else if (r[REQ_LINE]) begin
            w = 3'b010;
        end else if (r[REQ_REMOTE]) begin
            w = 3'b100;
        end else begin
            w = 3'b000;
        end
        return w;
    endfunction

    state_e              state_r, state_n_s;
    logic [2:0]          grant_r, grant_n_s;
    logic [1:0]          dir_r_s;
    logic                dir_l_r, dir_r_r;
    logic [1:0]          dir_n_s;
    logic [DUTY_W-1:0]   duty_l_r, duty_r_r, duty_l_n_s, duty_r_n_s;
    logic                enable_r, enable_n_s;
    logic                pause_r, pause_n_s;
    logic [1:0]          pend_dir_r, pend_dir_n_s;
    logic                tmr_load_s, tmr_zero_s;
    logic [CNT_W-1:0]    tmr_val_s;

    logic [2:0]          win_s;
    logic [1:0]          win_dir_s;
    logic [DUTY_W-1:0]   win_duty_l_s, win_duty_r_s;
    logic                any_req_s, fault_s;

    assign any_req_s = |req;
    assign fault_s   = |Disable;
    assign dir_r_s   = {dir_r_r, dir_l_r};

    drive_timer #(.CNT_W(CNT_W)) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (tmr_load_s),
        .load_val (tmr_val_s),
        .zero     (tmr_zero_s)
    );

    // Priority winner and its command, selected by the one-hot grant.
    always_comb begin
        win_s = prio_pick(req);
        case (win_s)
            3'b001: begin
                win_dir_s    = cmd_dir[REQ_AVOID];
                win_duty_l_s = cmd_duty[REQ_AVOID][0];
                win_duty_r_s = cmd_duty[REQ_AVOID][1];
            end
            3'b010: begin
                win_dir_s    = cmd_dir[REQ_LINE];
                win_duty_l_s = cmd_duty[REQ_LINE][0];
                win_duty_r_s = cmd_duty[REQ_LINE][1];
            end
            3'b100: begin
                win_dir_s    = cmd_dir[REQ_REMOTE];
                win_duty_l_s = cmd_duty[REQ_REMOTE][0];
                win_duty_r_s = cmd_duty[REQ_REMOTE][1];
            end
            default: begin
                win_dir_s    = 2'b00;
                win_duty_l_s = '0;
                win_duty_r_s = '0;
            end
        endcase
    end

    // Next state and next output values; outputs are registered from these.
    always_comb begin
        state_n_s    = state_r;
        grant_n_s    = 3'b000;
        dir_n_s      = dir_r_s;
        duty_l_n_s   = '0;
        duty_r_n_s   = '0;
        enable_n_s   = 1'b0;
        pause_n_s    = 1'b0;
        pend_dir_n_s = pend_dir_r;
        tmr_load_s   = 1'b0;
        tmr_val_s    = '0;

        case (state_r)
            ST_IDLE, ST_RUN: begin
                if (fault_s) begin
                    state_n_s  = ST_FAULT;
                    tmr_load_s = 1'b1;
                end else if (!any_req_s) begin
                    state_n_s = ST_IDLE;
                end else if (win_dir_s == dir_r_s) begin
                    state_n_s  = ST_RUN;
                    grant_n_s  = win_s;
                    duty_l_n_s = win_duty_l_s;
                    duty_r_n_s = win_duty_r_s;
                    enable_n_s = 1'b1;
                end else begin
                    // Reversal: park duties at zero and remember the target dirs.
                    state_n_s    = ST_DEADTIME;
                    grant_n_s    = win_s;
                    enable_n_s   = 1'b1;
                    pend_dir_n_s = win_dir_s;
                    tmr_load_s   = 1'b1;
                    tmr_val_s    = DEAD_LOAD;
                end
            end
            ST_DEADTIME: begin
                if (fault_s) begin
                    state_n_s  = ST_FAULT;
                    tmr_load_s = 1'b1;
                end else if (tmr_zero_s) begin
                    if (any_req_s) begin
                        state_n_s  = ST_RUN;
                        grant_n_s  = win_s;
                        dir_n_s    = win_dir_s;
                        duty_l_n_s = win_duty_l_s;
                        duty_r_n_s = win_duty_r_s;
                        enable_n_s = 1'b1;
                    end else begin
                        state_n_s = ST_IDLE;
                        dir_n_s   = pend_dir_r;
                    end
                end else begin
                    grant_n_s  = win_s;
                    enable_n_s = 1'b1;
                end
            end
            ST_FAULT: begin
                if (fault_s) begin
                    state_n_s = ST_FAULT;
                end else begin
                    state_n_s  = ST_PAUSE;
                    pause_n_s  = 1'b1;
                    tmr_load_s = 1'b1;
                    tmr_val_s  = PAUSE_LOAD;
                end
            end
            ST_PAUSE: begin
                if (fault_s) begin
                    state_n_s  = ST_FAULT;
                    tmr_load_s = 1'b1;
                end else if (tmr_zero_s) begin
                    state_n_s = ST_IDLE;
                end else begin
                    pause_n_s = 1'b1;
                end
            end
            default: begin
                state_n_s = ST_IDLE;
            end
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            grant_r    <= 3'b000;
            dir_l_r    <= 1'b1;
            dir_r_r    <= 1'b1;
            duty_l_r   <= '0;
            duty_r_r   <= '0;
            enable_r   <= 1'b0;
            pause_r    <= 1'b0;
            pend_dir_r <= 2'b11;
        end else begin
            state_r    <= state_n_s;
            grant_r    <= grant_n_s;
            dir_l_r    <= dir_n_s[0];
            dir_r_r    <= dir_n_s[1];
            duty_l_r   <= duty_l_n_s;
            duty_r_r   <= duty_r_n_s;
            enable_r   <= enable_n_s;
            pause_r    <= pause_n_s;
            pend_dir_r <= pend_dir_n_s;
        end
    end

    assign grant  = grant_r;
    assign dir_l  = dir_l_r;
    assign dir_r  = dir_r_r;
    assign duty_l = duty_l_r;
    assign duty_r = duty_r_r;
    assign Enable = enable_r;
    assign Pause  = pause_r;
    assign state  = state_r;

endmodule

// File: tb/tb_drive_arbiter.sv
// Directed bench for drive_arbiter with short dead time and pause intervals.
module tb_drive_arbiter;

    localparam int PC = 20;
    localparam int DC = 4;

    logic                  clk;
    logic                  reset;
    logic [1:0]            Disable;
    logic [2:0]            req;
    logic [2:0][1:0]       cmd_dir;
    logic [2:0][1:0][7:0]  cmd_duty;
    logic [2:0]            grant;
    logic                  dir_l, dir_r;
    logic [7:0]            duty_l, duty_r;
    logic                  Enable, Pause;
    logic [2:0]            state;

    int total  = 0;
    int passed = 0;

    drive_arbiter #(.PAUSE_CYCLES(PC), .DEADTIME_CYCLES(DC), .DUTY_W(8)) dut (
        .clk(clk), .reset(reset), .Disable(Disable), .req(req),
        .cmd_dir(cmd_dir), .cmd_duty(cmd_duty), .grant(grant),
        .dir_l(dir_l), .dir_r(dir_r), .duty_l(duty_l), .duty_r(duty_r),
        .Enable(Enable), .Pause(Pause), .state(state)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Observed output bundle: {grant, dir_r, dir_l, duty_l, duty_r, Enable, Pause, state}
    logic [25:0] obs;
    assign obs = {grant, dir_r, dir_l, duty_l, duty_r, Enable, Pause, state};

    function automatic logic [25:0] ex(input logic [2:0] g, input logic [1:0] d,
                                       input logic [7:0] dl, input logic [7:0] dr,
                                       input logic en, input logic p, input logic [2:0] st);
        return {g, d, dl, dr, en, p, st};
    endfunction

    typedef struct {
        logic [2:0]  req;
        logic [5:0]  dir;
        logic [1:0]  dis;
        logic [25:0] exp;
    } vec_t;

    vec_t vecs[20];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act === expv) passed++;
        else $display("FAIL %s: got %h, expected %h", nm, act, expv);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset   = 1'b1;
        Disable = 2'b00;
        req     = 3'b000;
        cmd_dir = 6'b111111;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic count_pause(output int n, output logic en_seen);
        n = 0;
        en_seen = 1'b0;
        while (Pause === 1'b1 && n < 100) begin
            n++;
            if (Enable !== 1'b0) en_seen = 1'b1;
            tick();
        end
    endtask

    initial begin
        int   n;
        logic en_seen;
        logic bad;

        reset    = 1'b1;
        Disable  = 2'b00;
        req      = 3'b000;
        cmd_dir  = 6'b111111;
        cmd_duty[0] = {8'h80, 8'h80};
        cmd_duty[1] = {8'h12, 8'h21};
        cmd_duty[2] = {8'h40, 8'h40};

        // dir field layout: [5:4] remote, [3:2] line, [1:0] avoid; each {right,left}
        vecs[0]  = '{3'b000, 6'b111111, 2'b00, ex(3'b000, 2'b11, 8'h00, 8'h00, 1'b0, 1'b0, 3'd0)};
        vecs[1]  = '{3'b100, 6'b111111, 2'b00, ex(3'b100, 2'b11, 8'h40, 8'h40, 1'b1, 1'b0, 3'd1)};
        vecs[2]  = '{3'b100, 6'b111111, 2'b00, ex(3'b100, 2'b11, 8'h40, 8'h40, 1'b1, 1'b0, 3'd1)};
        vecs[3]  = '{3'b101, 6'b111100, 2'b00, ex(3'b001, 2'b11, 8'h00, 8'h00, 1'b1, 1'b0, 3'd2)};
        vecs[4]  = '{3'b101, 6'b111100, 2'b00, ex(3'b001, 2'b11, 8'h00, 8'h00, 1'b1, 1'b0, 3'd2)};
        vecs[5]  = '{3'b101, 6'b111100, 2'b00, ex(3'b001, 2'b11, 8'h00, 8'h00, 1'b1, 1'b0, 3'd2)};
        vecs[6]  = '{3'b101, 6'b111100, 2'b00, ex(3'b001, 2'b11, 8'h00, 8'h00, 1'b1, 1'b0, 3'd2)};
        vecs[7]  = '{3'b101, 6'b111100, 2'b00, ex(3'b001, 2'b00, 8'h80, 8'h80, 1'b1, 1'b0, 3'd1)};
        vecs[8]  = '{3'b111, 6'b111100, 2'b00, ex(3'b001, 2'b00, 8'h80, 8'h80, 1'b1, 1'b0, 3'd1)};
        vecs[9]  = '{3'b110, 6'b110000, 2'b00, ex(3'b010, 2'b00, 8'h21, 8'h12, 1'b1, 1'b0, 3'd1)};
        vecs[10] = '{3'b000, 6'b110000, 2'b00, ex(3'b000, 2'b00, 8'h00, 8'h00, 1'b0, 1'b0, 3'd0)};
        vecs[11] = '{3'b010, 6'b110000, 2'b00, ex(3'b010, 2'b00, 8'h21, 8'h12, 1'b1, 1'b0, 3'd1)};
        vecs[12] = '{3'b010, 6'b110100, 2'b00, ex(3'b010, 2'b00, 8'h00, 8'h00, 1'b1, 1'b0, 3'd2)};
        vecs[13] = '{3'b000, 6'b110100, 2'b00, ex(3'b000, 2'b00, 8'h00, 8'h00, 1'b1, 1'b0, 3'd2)};
        vecs[14] = '{3'b000, 6'b110100, 2'b00, ex(3'b000, 2'b00, 8'h00, 8'h00, 1'b1, 1'b0, 3'd2)};
        vecs[15] = '{3'b000, 6'b110100, 2'b00, ex(3'b000, 2'b00, 8'h00, 8'h00, 1'b1, 1'b0, 3'd2)};
        vecs[16] = '{3'b000, 6'b110100, 2'b00, ex(3'b000, 2'b01, 8'h00, 8'h00, 1'b0, 1'b0, 3'd0)};
        vecs[17] = '{3'b000, 6'b110100, 2'b01, ex(3'b000, 2'b01, 8'h00, 8'h00, 1'b0, 1'b0, 3'd3)};
        vecs[18] = '{3'b000, 6'b110100, 2'b01, ex(3'b000, 2'b01, 8'h00, 8'h00, 1'b0, 1'b0, 3'd3)};
        vecs[19] = '{3'b000, 6'b110100, 2'b00, ex(3'b000, 2'b01, 8'h00, 8'h00, 1'b0, 1'b1, 3'd4)};

        do_reset();
        for (int i = 0; i < 20; i++) begin
            req     = vecs[i].req;
            cmd_dir = vecs[i].dir;
            Disable = vecs[i].dis;
            tick();
            chk($sformatf("vec%0d", i), 32'(obs), 32'(vecs[i].exp));
        end

        // Fault for 10 cycles, then a full pause before re-arming.
        do_reset();
        req = 3'b100;
        tick();
        chk("a_run", 32'(obs), 32'(ex(3'b100, 2'b11, 8'h40, 8'h40, 1'b1, 1'b0, 3'd1)));
        Disable = 2'b01;
        tick();
        chk("a_fault_resp", 32'(obs), 32'(ex(3'b000, 2'b11, 8'h00, 8'h00, 1'b0, 1'b0, 3'd3)));
        bad = 1'b0;
        repeat (9) begin
            tick();
            if (obs !== ex(3'b000, 2'b11, 8'h00, 8'h00, 1'b0, 1'b0, 3'd3)) bad = 1'b1;
        end
        chk("a_fault_hold", 32'(bad), 32'd0);
        Disable = 2'b00;
        tick();
        count_pause(n, en_seen);
        chk("a_pause_len", 32'(n), 32'(PC));
        chk("a_pause_no_en", 32'(en_seen), 32'd0);
        chk("a_pause_exit", 32'(obs), 32'(ex(3'b000, 2'b11, 8'h00, 8'h00, 1'b0, 1'b0, 3'd0)));
        tick();
        chk("a_resume", 32'(obs), 32'(ex(3'b100, 2'b11, 8'h40, 8'h40, 1'b1, 1'b0, 3'd1)));

        // Disable glitch at pause cycle 12 restarts the full pause.
        do_reset();
        req = 3'b100;
        tick();
        Disable = 2'b01;
        tick();
        Disable = 2'b00;
        tick();
        repeat (11) tick();
        chk("b_pause12", 32'(obs), 32'(ex(3'b000, 2'b11, 8'h00, 8'h00, 1'b0, 1'b1, 3'd4)));
        Disable = 2'b10;
        tick();
        chk("b_refault", 32'(obs), 32'(ex(3'b000, 2'b11, 8'h00, 8'h00, 1'b0, 1'b0, 3'd3)));
        Disable = 2'b00;
        tick();
        count_pause(n, en_seen);
        chk("b_pause_len", 32'(n), 32'(PC));
        chk("b_pause_exit", 32'(obs), 32'(ex(3'b000, 2'b11, 8'h00, 8'h00, 1'b0, 1'b0, 3'd0)));

        // Disable lands on the dead-time expiry edge: fault wins, dirs unchanged.
        do_reset();
        req = 3'b100;
        tick();
        req     = 3'b101;
        cmd_dir = 6'b111100;
        tick();
        repeat (DC - 1) tick();
        chk("c_dead_last", 32'(obs), 32'(ex(3'b001, 2'b11, 8'h00, 8'h00, 1'b1, 1'b0, 3'd2)));
        Disable = 2'b01;
        tick();
        chk("c_fault_expiry", 32'(obs), 32'(ex(3'b000, 2'b11, 8'h00, 8'h00, 1'b0, 1'b0, 3'd3)));
        Disable = 2'b00;
        tick();
        chk("c_pause_start", 32'(obs), 32'(ex(3'b000, 2'b11, 8'h00, 8'h00, 1'b0, 1'b1, 3'd4)));

        // Asynchronous reset in the middle of dead time, then immediate run.
        do_reset();
        req = 3'b100;
        tick();
        req     = 3'b101;
        cmd_dir = 6'b111100;
        tick();
        tick();
        chk("d_in_dead", 32'(obs), 32'(ex(3'b001, 2'b11, 8'h00, 8'h00, 1'b1, 1'b0, 3'd2)));
        #2 reset = 1'b1;
        #1;
        chk("d_async_reset", 32'(obs), 32'(ex(3'b000, 2'b11, 8'h00, 8'h00, 1'b0, 1'b0, 3'd0)));
        #1 reset = 1'b0;
        req     = 3'b100;
        cmd_dir = 6'b111111;
        tick();
        chk("d_run_no_pause", 32'(obs), 32'(ex(3'b100, 2'b11, 8'h40, 8'h40, 1'b1, 1'b0, 3'd1)));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
